// File: rtl/joybus_resp_rx.sv
// JOYBUS response receiver: decodes the controller's pulse-width coded reply
// (falling edge every bit, level sampled mid-bit) into a RESP_BITS word.
module joybus_resp_rx #(
  parameter int RESP_BITS      = 32,
  parameter int SAMPLE_CYCLES  = 50,
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_start,
  input  logic                 JB_RX,
  output logic [RESP_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic                 rx_busy
);

  localparam int BW = $clog2(RESP_BITS + 1);
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    SAMPLE,
    WAIT_RISE,
    STOP_FALL,
    STOP_RISE
  } state_t;

  state_t state;
  state_t state_n;

  logic                 sync_p0;
  logic                 sync_p1;
  logic                 prev_p2;
  logic                 line;
  logic                 fall;

  logic [TW-1:0]        tcnt;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [RESP_BITS-1:0] shreg;

  logic                 tmo;
  logic                 arm;
  logic                 shift_en;
  logic                 load_en;
  logic                 vld_n;
  logic                 err_n;

  // Stage p0/p1: metastability synchronizer; p2 holds the previous level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= JB_RX;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign line = sync_p1;
  assign fall = prev_p2 & ~sync_p1;
  assign tmo  = (tcnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    arm      = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    vld_n    = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_start) begin
          arm     = 1'b1;
          state_n = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          state_n = SAMPLE;
        end else if (tmo) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      SAMPLE: begin
        if (scnt == SAMPLE_LAST) begin
          shift_en = 1'b1;
          state_n  = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (line) begin
          state_n = (bcnt < BIT_LAST) ? WAIT_FALL : STOP_FALL;
        end else if (tmo) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      STOP_FALL: begin
        if (fall) begin
          state_n = STOP_RISE;
        end else if (tmo) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      STOP_RISE: begin
        if (line) begin
          load_en = 1'b1;
          vld_n   = 1'b1;
          state_n = IDLE;
        end else if (tmo) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters restart on every state change, so each waiting state gets a full timeout window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      scnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      if (state_n != state)   tcnt <= '0;
      else if (tcnt != TMO_LAST) tcnt <= tcnt + 1'b1;

      if (state_n != state)   scnt <= '0;
      else if (state == SAMPLE) scnt <= scnt + 1'b1;

      if (arm)                               bcnt <= '0;
      else if (shift_en && bcnt != BIT_LAST) bcnt <= bcnt + 1'b1;

      if (arm)           shreg <= '0;
      else if (shift_en) shreg <= {shreg[RESP_BITS-2:0], line};
    end
  end

  // Output stage: data only ever changes on a complete frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      if (load_en) rx_data <= shreg;
      rx_valid <= vld_n;
      rx_err   <= err_n;
      rx_busy  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_joybus_resp_rx.sv
// Bench for joybus_resp_rx: table of directed frames, a reset-abort sequence,
// and randomized frames checked against an outcome-level reference model.
module tb_joybus_resp_rx;

  localparam int TO = 2500;
  localparam int SC = 50;
  localparam int WAIT_LIMIT = TO + SC + 200;

  logic        clk;
  logic        rst;
  logic        rx_start;
  logic        jb;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic        rx_busy;

  joybus_resp_rx #(
    .RESP_BITS     (32),
    .SAMPLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_start(rx_start),
    .JB_RX   (jb),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .rx_busy (rx_busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int t_last = 0;
  int t_pulse = 0;
  logic pulse_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic [31:0] model_data = '0;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    bit          stop;
    bit          stuck;
    int          jit;
    bit          dbl;
    bit          exp_valid;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int v, input int lo, input int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, v, lo, hi);
    end
  endtask

  // Pulse bookkeeping: exclusivity, single-cycle width, busy held up to the pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid || rx_err) begin
        check("valid_err_overlap", {31'd0, rx_valid & rx_err}, 32'd0);
        check("pulse_width", {31'd0, pulse_prev}, 32'd0);
        check("busy_before_pulse", {31'd0, busy_prev}, 32'd1);
        if (rx_valid) vld_cnt++;
        if (rx_err) err_cnt++;
        t_pulse = cyc;
      end
      pulse_prev = rx_valid | rx_err;
      busy_prev  = rx_busy;
    end else begin
      pulse_prev = 1'b0;
      busy_prev  = 1'b0;
    end
  end

  // Outcome-level model: only a complete frame with its stop bit updates the data
  task automatic predict(input vec_t v, output bit ev, output bit ee, output logic [31:0] ed);
    ev = (v.nbits == 32) && v.stop && !v.stuck;
    ee = !ev;
    ed = ev ? v.data : model_data;
  endtask

  task automatic drive_line(input logic val);
    jb = val;
    t_last = cyc;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_start = 1'b1;
    t_last = cyc;
    @(negedge clk);
    rx_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int jit, input bit dbl);
    int lo;
    lo = b ? 25 : 75;
    if (jit > 0) lo = lo + int'($urandom_range(0, 2 * jit)) - jit;
    @(negedge clk);
    drive_line(1'b0);
    if (dbl) rx_start = 1'b1;
    repeat (lo) begin
      @(negedge clk);
      rx_start = 1'b0;
    end
    drive_line(1'b1);
    repeat (100 - lo - 1) @(negedge clk);
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int v0, e0, n, d;
    v0 = vld_cnt;
    e0 = err_cnt;
    pulse_start();
    check({tag, "_busy_after_start"}, {31'd0, rx_busy}, 32'd1);
    for (int i = 0; i < v.nbits; i++) begin
      send_bit(v.data[31-i], v.jit, v.dbl && (i == 4));
      if (v.dbl && i == 4) check({tag, "_busy_mid_frame"}, {31'd0, rx_busy}, 32'd1);
    end
    if (v.stuck) begin
      @(negedge clk);
      drive_line(1'b0);
    end else if (v.stop) begin
      @(negedge clk);
      drive_line(1'b0);
      repeat (25) @(negedge clk);
      drive_line(1'b1);
    end
    n = 0;
    while (vld_cnt == v0 && err_cnt == e0 && n < WAIT_LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_outcome_seen"}, {31'd0, n >= WAIT_LIMIT}, 32'd0);
    check({tag, "_valid_pulses"}, vld_cnt - v0, {31'd0, v.exp_valid});
    check({tag, "_err_pulses"}, err_cnt - e0, {31'd0, v.exp_err});
    check({tag, "_rx_data"}, rx_data, v.exp_data);
    d = t_pulse - t_last;
    if (v.exp_valid) check_rng({tag, "_valid_delay"}, d, 2, 5);
    else             check_rng({tag, "_err_delay"}, d, TO - 2, TO + SC + 20);
    @(negedge clk);
    #1;
    check({tag, "_busy_after_pulse"}, {31'd0, rx_busy}, 32'd0);
    model_data = v.exp_data;
    drive_line(1'b1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    vec_t rv;
    bit ev, ee;
    logic [31:0] ed;
    int v0, e0, kind;

    tbl[0] = '{32'h8000_0FF1, 32, 1, 0, 0,  0, 1, 0, 32'h8000_0FF1};
    tbl[1] = '{32'h0000_0000,  0, 0, 0, 0,  0, 0, 1, 32'h8000_0FF1};
    tbl[2] = '{32'hA5A5_5A5A, 10, 0, 1, 0,  0, 0, 1, 32'h8000_0FF1};
    tbl[3] = '{32'h0F0F_1234, 32, 0, 0, 0,  0, 0, 1, 32'h8000_0FF1};
    tbl[4] = '{32'hCAFE_BABE, 32, 1, 0, 10, 1, 1, 0, 32'hCAFE_BABE};
    tbl[5] = '{32'hFFFF_FFFF, 32, 1, 0, 10, 0, 1, 0, 32'hFFFF_FFFF};
    tbl[6] = '{32'h0000_0000, 32, 1, 0, 10, 0, 1, 0, 32'h0000_0000};

    rst = 1'b1;
    rx_start = 1'b0;
    jb = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_err", {31'd0, rx_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) run_case($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a frame: abandon silently, then accept a fresh frame
    pulse_start();
    rv = '{32'hDEAD_BEEF, 16, 0, 0, 0, 0, 0, 0, 32'd0};
    for (int i = 0; i < 16; i++) send_bit(rv.data[31-i], 0, 1'b0);
    v0 = vld_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", rx_data, 32'd0);
    check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("midrst_pulses", {31'd0, rx_valid | rx_err}, 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (TO + 100) @(negedge clk);
    check("midrst_no_valid", vld_cnt - v0, 32'd0);
    check("midrst_no_err", err_cnt - e0, 32'd0);
    check("midrst_idle", {31'd0, rx_busy}, 32'd0);
    model_data = '0;
    run_case("post_rst", '{32'h1234_5678, 32, 1, 0, 0, 0, 1, 0, 32'h1234_5678});

    for (int r = 0; r < 8; r++) begin
      kind = int'($urandom_range(0, 3));
      rv.data  = $urandom;
      rv.jit   = int'($urandom_range(0, 10));
      rv.dbl   = ($urandom_range(0, 1) == 1);
      rv.nbits = 32;
      rv.stop  = 1'b1;
      rv.stuck = 1'b0;
      if (kind == 2) begin
        rv.stuck = 1'b1;
        rv.stop  = 1'b0;
        rv.nbits = int'($urandom_range(5, 32));
      end else if (kind == 3) begin
        rv.stop  = 1'b0;
        rv.nbits = int'($urandom_range(5, 32));
      end
      predict(rv, ev, ee, ed);
      rv.exp_valid = ev;
      rv.exp_err   = ee;
      rv.exp_data  = ed;
      run_case($sformatf("rand%0d", r), rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joybus_resp_rx.md
JOYBUS_RESP_RX -- requirements
Module: joybus_resp_rx

Interface
REQ-001 Parameter: RESP_BITS, default 32, number of response data bits expected after the command.
REQ-002 Parameter: SAMPLE_CYCLES, default 50, clock cycles from a detected falling edge to the bit sample point (2 us at 25 MHz).
REQ-003 Parameter: TIMEOUT_CYCLES, default 2500, maximum cycles the block waits for any expected line edge (100 us at 25 MHz).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, rising-edge, 25 MHz nominal.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rx_start  input  1  single-cycle pulse from the transmitter's tx_done; arms reception.
REQ-008 JB_RX  input  1  raw JOYBUS line level (asynchronous, pulled high when idle).
REQ-009 rx_data  output  RESP_BITS  last good response, first received bit in MSB.
REQ-010 rx_valid  output  1  one-cycle pulse: rx_data updated with a complete response.
REQ-011 rx_err  output  1  one-cycle pulse: reception aborted by timeout.
REQ-012 rx_busy  output  1  high from the cycle after an accepted rx_start until rx_valid or rx_err.

Function
REQ-013 JB_RX shall pass through a 2-flop synchronizer; all decoding uses the synchronized level; a falling edge is synchronized-high then synchronized-low on consecutive cycles.
REQ-014 States: IDLE, WAIT_FALL, SAMPLE, WAIT_RISE, STOP_FALL, STOP_RISE.
REQ-015 IDLE: rx_start=1 -> WAIT_FALL, clear bit counter and timeout counter; rx_start ignored in every other state.
REQ-016 WAIT_FALL: falling edge -> SAMPLE, reset the sample counter to 0; timeout counter reaching TIMEOUT_CYCLES-1 -> IDLE with rx_err pulse.
REQ-017 SAMPLE: when the sample counter reaches SAMPLE_CYCLES-1, shift the synchronized level (high=1, low=0) into the shift register LSB and increment the bit counter -> WAIT_RISE.
REQ-018 WAIT_RISE: synchronized level high -> WAIT_FALL if bit counter < RESP_BITS, else STOP_FALL; timeout applies (line stuck low -> rx_err).
REQ-019 STOP_FALL: falling edge -> STOP_RISE; STOP_RISE: synchronized high -> IDLE, load rx_data from the shift register, pulse rx_valid in that same cycle.
REQ-020 The timeout counter shall clear on entry to every waiting state (WAIT_FALL, WAIT_RISE, STOP_FALL, STOP_RISE) and saturate; any timeout returns to IDLE with rx_err, rx_data unchanged.
REQ-021 rx_valid and rx_err shall never assert in the same cycle and never for more than one cycle.
REQ-022 The bit counter shall be $clog2(RESP_BITS+1) bits wide and shall not wrap.
REQ-023 A partial or errored response shall never modify rx_data.
REQ-024 rx_start coincident with rx_valid or rx_err (already in IDLE next cycle) is ignored; rx_start is only sampled in IDLE.
REQ-025 rx_busy = (state != IDLE), registered.

Reset
REQ-026 While rst=1: state IDLE, rx_data=0, rx_valid=0, rx_err=0, rx_busy=0, all counters, shift register and synchronizer flops cleared (synchronizer to 1, idle line level).
REQ-027 Reset asserted mid-reception shall abandon the frame with no rx_valid/rx_err pulse; after release the block waits for a new rx_start.

Verification
REQ-028 Nominal: rx_start, then 32 bits of 0x8000_0FF1 (bit = 100 cycles; '0' = 75 low/25 high, '1' = 25 low/75 high), stop bit 25 low -> rx_valid one pulse, rx_data=0x80000FF1, rx_busy low the next cycle.
REQ-029 Silent controller: rx_start, line held high 2500 cycles -> rx_err one pulse at timeout, rx_data unchanged, rx_busy low.
REQ-030 Stuck low: line driven low after 10 bits and held -> rx_err after 2500 cycles in WAIT_RISE; previous rx_data retained.
REQ-031 Reset mid-frame: rst asserted after 16 bits -> outputs at reset values, no pulses; new full frame 0x12345678 afterwards -> rx_valid, rx_data=0x12345678.
REQ-032 Busy rejection: second rx_start during bit 5 -> ignored, frame completes normally with correct data; bits with ±10-cycle edge jitter still decode correctly.
REQ-033 No stop bit: 32 good bits then line held high -> rx_err after 2500 cycles, rx_data unchanged.
